period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 138 +++++++++++++
 tb/tb_period_meter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Period and high-time meter for a slow asynchronous input.
// Results are delivered through a valid/ready handshake.
module period_meter #(
    parameter int               CNT_W     = 26,
    parameter logic [CNT_W-1:0] SAT_COUNT = {CNT_W{1'b1}}
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    output logic             dropped,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             sync1;
    logic             sync2;
    logic             sync_prev;
    logic             rise;
    logic             enable_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_cnt_d;
    logic [CNT_W-1:0] cap_period;
    logic [CNT_W-1:0] cap_high;
    logic             capture;
    logic             ovf_hit;

    assign rise       = sync2 & ~sync_prev;
    assign busy       = (state_q != IDLE);
    // The rising-edge cycle itself belongs to the period being closed.
    assign cap_period = per_cnt_q + CNT_W'(1);
    assign cap_high   = hi_cnt_q + CNT_W'(sync2);

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        capture   = 1'b0;
        ovf_hit   = 1'b0;
        if (!enable) begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        capture   = 1'b1;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end else if (per_cnt_q == SAT_COUNT) begin
                        ovf_hit   = 1'b1;
                        state_d   = ARM;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_W'(1);
                        if (sync2) begin
                            hi_cnt_d = hi_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync_prev  <= 1'b0;
            enable_q   <= 1'b0;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1     <= sig_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            enable_q  <= enable;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
            if (capture) begin
                overflow <= 1'b0;
                if (!valid || ready) begin
                    period_out <= cap_period;
                    high_out   <= cap_high;
                    valid      <= 1'b1;
                end else begin
                    dropped <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            // A fresh enable starts a new session with a clean drop flag.
            if (enable && !enable_q) begin
                dropped <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed scenarios plus randomized waveforms,
// every cycle compared against a timestamp-based reference model.
module tb_period_meter;

    localparam int W   = 8;
    localparam int SAT = 255;

    logic         clk_in = 1'b0;
    logic         reset  = 1'b0;
    logic         sig_in = 1'b0;
    logic         enable = 1'b0;
    logic         ready  = 1'b0;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         valid;
    logic         overflow;
    logic         dropped;
    logic         busy;

    period_meter #(
        .CNT_W    (W),
        .SAT_COUNT(8'(SAT))
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .enable    (enable),
        .period_out(period_out),
        .high_out  (high_out),
        .valid     (valid),
        .ready     (ready),
        .overflow  (overflow),
        .dropped   (dropped),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: rising edges are timestamped by edge number and
    // results are differences of timestamps / running high-sample sums.
    typedef enum {M_IDLE, M_ARM, M_MEAS} mode_t;
    mode_t mode   = M_IDLE;
    int    edge_n = 0;
    int    t0     = 0;
    int    hi_acc = 0;
    int    hi_t0  = 0;
    int    m_per  = 0;
    int    m_hi   = 0;
    bit    m_valid, m_ovf, m_drop, en_prev;
    bit    d1, d2, d3;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit syncv;
        bit rise;
        bit cap;
        int new_per;
        int new_hi;
        edge_n++;
        syncv   = d2;
        rise    = d2 && !d3;
        cap     = 1'b0;
        new_per = 0;
        new_hi  = 0;
        if (!reset) begin
            mode    = M_IDLE;
            m_per   = 0;
            m_hi    = 0;
            m_valid = 0;
            m_ovf   = 0;
            m_drop  = 0;
            en_prev = 0;
            d1      = 0;
            d2      = 0;
            d3      = 0;
            hi_acc  = 0;
        end else begin
            hi_acc += int'(syncv);
            if (!enable) begin
                mode = M_IDLE;
            end else begin
                case (mode)
                    M_IDLE: mode = M_ARM;
                    M_ARM: begin
                        if (rise) begin
                            mode  = M_MEAS;
                            t0    = edge_n;
                            hi_t0 = hi_acc;
                        end
                    end
                    M_MEAS: begin
                        if (rise) begin
                            cap     = 1'b1;
                            new_per = edge_n - t0;
                            new_hi  = hi_acc - hi_t0;
                            t0      = edge_n;
                            hi_t0   = hi_acc;
                        end else if (edge_n - t0 - 1 == SAT) begin
                            m_ovf = 1;
                            mode  = M_ARM;
                        end
                    end
                    default: mode = M_IDLE;
                endcase
            end
            if (cap) begin
                m_ovf = 0;
                if (!m_valid || ready) begin
                    m_per   = new_per;
                    m_hi    = new_hi;
                    m_valid = 1;
                end else begin
                    m_drop = 1;
                end
            end else if (m_valid && ready) begin
                m_valid = 0;
            end
            if (enable && !en_prev) m_drop = 0;
            en_prev = enable;
            d3 = d2;
            d2 = d1;
            d1 = sig_in;
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check("period_out", 32'(period_out), 32'(m_per));
        check("high_out", 32'(high_out), 32'(m_hi));
        check("valid", 32'(valid), 32'(m_valid));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("dropped", 32'(dropped), 32'(m_drop));
        check("busy", 32'(busy), 32'(mode != M_IDLE));
    endtask

    task automatic wave(input int per, input int hi, input int n,
                        input bit rnd_ready);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) begin
                sig_in = (c < hi);
                if (rnd_ready) ready = 1'($urandom_range(0, 1));
                step();
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        sig_in = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int per;
        int hi;

        // Reset state
        repeat (3) step();
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_period", 32'(period_out), 0);

        // Steady 10/4 waveform, consumer always ready
        reset  = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        wave(10, 4, 6, 1'b0);
        check("r030_period", 32'(period_out), 10);
        check("r030_high", 32'(high_out), 4);

        // Drain, then 7/3 with consumer stalled
        enable = 1'b0;
        idle_cycles(3);
        ready  = 1'b0;
        enable = 1'b1;
        wave(7, 3, 4, 1'b0);
        check("r031_period", 32'(period_out), 7);
        check("r031_high", 32'(high_out), 3);
        check("r031_dropped", 32'(dropped), 1);
        ready = 1'b1;
        idle_cycles(1);
        check("r031_valid_clr", 32'(valid), 0);
        check("r031_hold", 32'(period_out), 7);

        // Randomized periods and back-pressure
        enable = 1'b0;
        idle_cycles(2);
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            per = $urandom_range(2, 40);
            hi  = $urandom_range(1, per - 1);
            wave(per, hi, 1, 1'b1);
        end

        // Overflow after a single rise, then recovery
        ready  = 1'b1;
        sig_in = 1'b1;
        step();
        idle_cycles(300);
        check("r032_ovf", 32'(overflow), 1);
        check("r032_valid", 32'(valid), 0);
        check("r032_busy", 32'(busy), 1);
        wave(20, 5, 2, 1'b0);
        idle_cycles(5);
        check("r032_period", 32'(period_out), 20);
        check("r032_ovf_clr", 32'(overflow), 0);

        // Enable dropped mid-measurement
        wave(9, 4, 2, 1'b0);
        sig_in = 1'b1;
        step();
        step();
        enable = 1'b0;
        step();
        check("r033_busy", 32'(busy), 0);
        enable = 1'b1;
        wave(9, 4, 3, 1'b0);
        check("r033_period", 32'(period_out), 9);

        // Reset mid-measurement with a held result
        ready = 1'b0;
        wave(10, 4, 2, 1'b0);
        sig_in = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("r034_valid", 32'(valid), 0);
        check("r034_period", 32'(period_out), 0);
        reset = 1'b1;
        ready = 1'b1;
        wave(10, 4, 4, 1'b0);
        check("r034_period2", 32'(period_out), 10);
        check("r034_high2", 32'(high_out), 4);

        // Minimum measurable period
        wave(2, 1, 6, 1'b0);
        check("min_period", 32'(period_out), 2);
        check("min_high", 32'(high_out), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
